// File: rtl/timer_arbiter.sv
// timer_arbiter: one prescaled countdown timer shared round-robin between three
// requesters (keypad timeout, unlock hold, buzzer duration).
//
// A free-running prescaler produces a one-cycle tick every DIVIDER+1 clocks.
// A requester holds req high with a tick count on its dur input. The granted
// owner sees gnt while the timer runs and a one-cycle done pulse on expiry.
// Dropping req while running aborts the timer without a done pulse.
//
// Optional build macro TMR_PRESCALE_SYNC_EN: when defined, the prescaler is
// cleared in the grant cycle, making expiry exact at grant + dur*(DIVIDER+1).
// When undefined, the prescaler free-runs and expiry jitters by up to a tick.
//
// Ports:
//   clk     system clock
//   rst     asynchronous active-low reset
//   req     per-requester level request, held until done
//   dur0-2  per-requester duration in ticks, sampled at grant
//   gnt     one-hot owner of the running timer
//   done    one-hot, one-cycle expiry pulse to the owner
//   busy    high while running or signalling done
//   remain  current countdown value, 0 when not running
//   tick    prescaler terminal-count strobe
module timer_arbiter #(
    parameter int unsigned DIVIDER = 249999,
    parameter int unsigned PRE_W   = 25,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       req,
    input  logic [CNT_W-1:0] dur0,
    input  logic [CNT_W-1:0] dur1,
    input  logic [CNT_W-1:0] dur2,
    output logic [2:0]       gnt,
    output logic [2:0]       done,
    output logic             busy,
    output logic [CNT_W-1:0] remain,
    output logic             tick
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       rr_q, rr_d;

    logic [1:0]       winner;
    logic [1:0]       cand;
    logic             found;
    logic [CNT_W-1:0] win_dur;
    logic             grant;
    logic [2:0]       owner_onehot;

    function automatic logic [1:0] inc_mod3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    assign tick         = (pre_q == PRE_W'(DIVIDER));
    assign grant        = (state_q == StIdle) && (|req);
    assign owner_onehot = 3'b001 << owner_q;

    // Round-robin search starting at the pointer and wrapping upward mod 3.
    always_comb begin
        winner = rr_q;
        found  = 1'b0;
        cand   = rr_q;
        for (int i = 0; i < 3; i++) begin
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
            cand = inc_mod3(cand);
        end
    end

    always_comb begin
        case (winner)
            2'd0:    win_dur = dur0;
            2'd1:    win_dur = dur1;
            default: win_dur = dur2;
        endcase
    end

    always_comb begin
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
`ifdef TMR_PRESCALE_SYNC_EN
        // Restart the tick phase so the first tick lands a full period after grant.
        if (grant) begin
            pre_d = '0;
        end
`endif
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            pre_q    <= '0;
            remain_q <= '0;
            owner_q  <= 2'd0;
            rr_q     <= 2'd0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            remain_q <= remain_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d  = StRun;
                    owner_d  = winner;
                    remain_d = win_dur;
                end
            end
            StRun: begin
                // Abort wins over a coincident tick.
                if (!req[owner_q]) begin
                    state_d  = StIdle;
                    remain_d = '0;
                    rr_d     = inc_mod3(owner_q);
                end else if (remain_q == '0) begin
                    // Zero duration: expire the cycle after grant.
                    state_d  = StDone;
                end else if (tick) begin
                    if (remain_q == CNT_W'(1)) begin
                        state_d  = StDone;
                        remain_d = '0;
                    end else begin
                        remain_d = remain_q - CNT_W'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                rr_d    = inc_mod3(owner_q);
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs.
    always_comb begin
        gnt    = '0;
        done   = '0;
        busy   = 1'b0;
        remain = '0;
        unique case (state_q)
            StRun: begin
                gnt    = owner_onehot;
                busy   = 1'b1;
                remain = remain_q;
            end
            StDone: begin
                done = owner_onehot;
                busy = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter with DIVIDER=3 (tick every 4 cycles).
// Requests are launched in a cycle where tick is high so the grant cycle sees
// prescaler phase 0 in either build; exact-timing checks then hold in both.
module tb_timer_arbiter;

    localparam int unsigned DIV   = 3;
    localparam int unsigned PRE_W = 2;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [2:0]       req = 3'b000;
    logic [CNT_W-1:0] dur0 = '0;
    logic [CNT_W-1:0] dur1 = '0;
    logic [CNT_W-1:0] dur2 = '0;
    logic [2:0]       gnt;
    logic [2:0]       done;
    logic             busy;
    logic [CNT_W-1:0] remain;
    logic             tick;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    timer_arbiter #(
        .DIVIDER(DIV),
        .PRE_W  (PRE_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .dur0  (dur0),
        .dur1  (dur1),
        .dur2  (dur2),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .remain(remain),
        .tick  (tick)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to an idle cycle with tick high; a request set now is granted
    // with the prescaler at phase 0.
    task automatic wait_tick();
        int k = 0;
        while (!(tick === 1'b1 && busy === 1'b0) && k < 12) begin
            step();
            k++;
        end
        chk("align_tick", {31'd0, (tick === 1'b1 && busy === 1'b0)}, 32'd1);
    endtask

    task automatic wait_gnt(output int at);
        int k = 0;
        while (gnt === 3'b000 && k < 40) begin
            step();
            k++;
        end
        at = cyc;
        chk("gnt_seen", {31'd0, (gnt !== 3'b000)}, 32'd1);
    endtask

    task automatic wait_done(output int at);
        int k = 0;
        while (done === 3'b000 && k < 40) begin
            step();
            k++;
        end
        at = cyc;
        chk("done_seen", {31'd0, (done !== 3'b000)}, 32'd1);
    endtask

    logic [2:0] rr_exp [4];
    int g, g_prev, d, d_prev, last_tick;

    initial begin
        rr_exp = '{3'b010, 3'b100, 3'b001, 3'b010};

        // Reset state.
        step();
        step();
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_remain", remain, 0);
        chk("rst_tick", tick, 0);
        rst = 1'b1;

        // Basic timing, requester 0, dur 2.
        wait_tick();
        req = 3'b001; dur0 = 8'd2;
        step();                                   // G
        chk("basic_gnt", gnt, 3'b001);
        chk("basic_busy", busy, 1);
        chk("basic_remain_g", remain, 2);
        step(); step(); step();                   // G+3
        chk("basic_tick_g3", tick, 1);
        chk("basic_remain_g3", remain, 2);
        step();                                   // G+4
        chk("basic_remain_g4", remain, 1);
        chk("basic_tick_g4", tick, 0);
        step(); step(); step();                   // G+7
        chk("basic_tick_g7", tick, 1);
        chk("basic_done_g7", done, 0);
        step();                                   // G+8
        chk("basic_done_g8", done, 3'b001);
        chk("basic_gnt_g8", gnt, 0);
        chk("basic_remain_g8", remain, 0);
        chk("basic_busy_g8", busy, 1);
        req = 3'b000;
        step();                                   // G+9
        chk("basic_idle_busy", busy, 0);
        chk("basic_idle_done", done, 0);

        // Round robin, pointer is now at 1.
        req = 3'b111; dur0 = 8'd1; dur1 = 8'd1; dur2 = 8'd1;
        g_prev = 0; d_prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(g);
            chk("rr_gnt", gnt, rr_exp[k]);
            if (k > 0) begin
                chk("rr_done_to_gnt", g - d_prev, 2);
`ifdef TMR_PRESCALE_SYNC_EN
                chk("rr_spacing", g - g_prev, 6);
`else
                chk("rr_spacing_range", {31'd0, (g - g_prev >= 3 && g - g_prev <= 6)}, 32'd1);
`endif
            end
            wait_done(d);
            chk("rr_done_owner", done, rr_exp[k]);
            chk("rr_gnt_at_done", gnt, 0);
            if (k == 3) req = 3'b000;
            g_prev = g;
            d_prev = d;
        end

        // Abort of requester 1 (pointer at 2, so only req[1] can win).
        wait_tick();
        req = 3'b010; dur1 = 8'd5;
        step();                                   // G
        chk("abort_gnt", gnt, 3'b010);
        chk("abort_remain_g", remain, 5);
        repeat (6) step();                        // G+6
        chk("abort_remain_g6", remain, 4);
        req = 3'b000;
        step();                                   // G+7
        chk("abort_gnt_off", gnt, 0);
        chk("abort_remain_off", remain, 0);
        chk("abort_no_done", done, 0);
        chk("abort_busy_off", busy, 0);
        req = 3'b101; dur2 = 8'd9;                // pointer now 2: requester 2 wins
        step();
        chk("abort_next_gnt", gnt, 3'b100);
        chk("abort_next_remain", remain, 9);
        req = 3'b000;
        step();
        chk("abort2_gnt_off", gnt, 0);
        chk("abort2_no_done", done, 0);

        // Abort coinciding with the final tick: no done pulse.
        wait_tick();
        req = 3'b001; dur0 = 8'd1;
        step();                                   // G
        chk("prec_gnt", gnt, 3'b001);
        step(); step(); step();                   // G+3
        chk("prec_tick", tick, 1);
        req = 3'b000;
        step();                                   // G+4
        chk("prec_no_done", done, 0);
        chk("prec_gnt_off", gnt, 0);
        chk("prec_busy_off", busy, 0);

        // Zero duration on requester 2 (pointer at 1).
        req = 3'b100; dur2 = 8'd0;
        step();                                   // G
        chk("zero_gnt", gnt, 3'b100);
        chk("zero_remain", remain, 0);
        chk("zero_busy", busy, 1);
        step();                                   // G+1
        chk("zero_done", done, 3'b100);
        chk("zero_gnt_off", gnt, 0);
        req = 3'b000;
        step();                                   // G+2
        chk("zero_busy_off", busy, 0);

        // Request at an arbitrary prescaler phase.
        repeat ($urandom_range(0, 3)) step();
        req = 3'b001; dur0 = 8'd3;
        step();
        g = cyc;
        chk("free_gnt", gnt, 3'b001);
        chk("free_remain", remain, 3);
        last_tick = -1;
        d = -1;
        for (int k = 0; k < 20 && d < 0; k++) begin
            step();
            if (tick === 1'b1) begin
                if (last_tick >= 0) chk("free_tick_period", cyc - last_tick, 4);
                last_tick = cyc;
            end
            if (done !== 3'b000) begin
                d = cyc;
                chk("free_done_owner", done, 3'b001);
            end
        end
        chk("free_done_seen", {31'd0, (d >= 0)}, 32'd1);
`ifdef TMR_PRESCALE_SYNC_EN
        chk("free_done_time", d - g, 12);
`else
        chk("free_done_window", {31'd0, (d - g >= 9 && d - g <= 12)}, 32'd1);
`endif
        req = 3'b000;
        step();
        chk("free_idle", busy, 0);

        // Asynchronous reset mid-run (pointer at 1, requester 1 wins first).
        wait_tick();
        req = 3'b011; dur0 = 8'd5; dur1 = 8'd5;
        step();                                   // G
        chk("arst_gnt_before", gnt, 3'b010);
        step(); step(); step();                   // G+3
        chk("arst_tick_before", tick, 1);
        chk("arst_remain_before", remain, 5);
        rst = 1'b0;
        #1;
        chk("arst_gnt", gnt, 0);
        chk("arst_busy", busy, 0);
        chk("arst_remain", remain, 0);
        chk("arst_done", done, 0);
        chk("arst_tick", tick, 0);
        step();
        chk("arst_hold_done", done, 0);
        step();
        rst = 1'b1;
        step();                                   // first cycle after release edge
        g = cyc;
        chk("arst_regrant", gnt, 3'b001);
        chk("arst_regrant_remain", remain, 5);
        wait_done(d);
        chk("arst_done_owner", done, 3'b001);
`ifdef TMR_PRESCALE_SYNC_EN
        chk("arst_done_time", d - g, 20);
`else
        chk("arst_done_window", {31'd0, (d - g >= 17 && d - g <= 20)}, 32'd1);
`endif
        req = 3'b000;
        step();
        chk("arst_final_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
